// File: rtl/mul_if.sv
// EX-stage multiplier handshake: operation request, flush and result return.
interface mul_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [4:0]      ALUCtrl;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport slave (
    input  start, ALUCtrl, rs1, rs2, kill,
    output busy, done, result
  );

  modport master (
    output start, ALUCtrl, rs1, rs2, kill,
    input  busy, done, result
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier (MUL/MULH/MULHSU/MULHU) with sign fix-up.
// Optional MUL_EARLY_OUT_EN: leave CALC once the remaining multiplier bits are all zero.
//
// state  | meaning
// IDLE   | waiting for a multiply request
// CALC   | one multiplier bit per cycle into the 64-bit accumulator
// FIX    | negate accumulator when exactly one operand was negative
// DONE   | result valid, done pulse
module mul_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic  clk,
  input logic  rst_n,
  mul_if.slave bus
);

  localparam logic [4:0] OP_MUL    = 5'b10110;
  localparam logic [4:0] OP_MULH   = 5'b10111;
  localparam logic [4:0] OP_MULHSU = 5'b11000;
  localparam logic [4:0] OP_MULHU  = 5'b11001;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_mcand;
  logic [XLEN-1:0]     r_mplier;
  logic [XLEN-1:0]     r_result;
  logic [CNT_W-1:0]    r_cnt;
  logic [4:0]          r_op;
  logic                r_neg;

  logic                w_is_mul;
  logic                w_accept;
  logic                w_sa;
  logic                w_sb;
  logic                w_last;
  logic                w_done;
  logic [XLEN-1:0]     w_sel;
  logic [XLEN-1:0]     w_mplier_nxt;
  logic [2*XLEN-1:0]   w_addend;

  assign w_is_mul = (bus.ALUCtrl == OP_MUL) || (bus.ALUCtrl == OP_MULH) ||
                    (bus.ALUCtrl == OP_MULHSU) || (bus.ALUCtrl == OP_MULHU);
  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.kill && w_is_mul;

  assign w_sa = ((bus.ALUCtrl == OP_MULH) || (bus.ALUCtrl == OP_MULHSU)) && bus.rs1[XLEN-1];
  assign w_sb = (bus.ALUCtrl == OP_MULH) && bus.rs2[XLEN-1];

  assign w_mplier_nxt = r_mplier >> 1;
  assign w_addend     = {{XLEN{1'b0}}, r_mcand} << r_cnt;

`ifdef MUL_EARLY_OUT_EN
  assign w_last = (r_cnt == CNT_W'(XLEN-1)) || (w_mplier_nxt == '0);
`else
  assign w_last = (r_cnt == CNT_W'(XLEN-1));
`endif

  assign w_sel  = (r_op == OP_MUL) ? r_acc[XLEN-1:0] : r_acc[2*XLEN-1:XLEN];
  assign w_done = (r_state == S_DONE) && !bus.kill;

  // Result is presented straight from the accumulator during DONE so a kill
  // in that cycle can still leave the previous result untouched.
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = w_done;
  assign bus.result = w_done ? w_sel : r_result;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      S_CALC: begin
        if (bus.kill)    w_next = S_IDLE;
        else if (w_last) w_next = S_FIX;
      end
      S_FIX:   w_next = bus.kill ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_mcand  <= w_sa ? -bus.rs1 : bus.rs1;
        r_mplier <= w_sb ? -bus.rs2 : bus.rs2;
        r_neg    <= w_sa ^ w_sb;
        r_op     <= bus.ALUCtrl;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_CALC) begin
        if (r_mplier[0]) r_acc <= r_acc + w_addend;
        r_mplier <= w_mplier_nxt;
        r_cnt    <= r_cnt + CNT_W'(1);
      end else if (r_state == S_FIX) begin
        if (r_neg) r_acc <= -r_acc;
      end
      if (w_done) r_result <= w_sel;
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vectors, randomized ops against a
// sign-extension reference model, filtering, kill, reset and back-to-back.
module tb_mul_unit;

  localparam logic [4:0] OP_MUL    = 5'b10110;
  localparam logic [4:0] OP_MULH   = 5'b10111;
  localparam logic [4:0] OP_MULHSU = 5'b11000;
  localparam logic [4:0] OP_MULHU  = 5'b11001;
  localparam int         LAT       = 34;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mul_if #(.XLEN(32)) bus ();

  mul_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'b0, a};
    eb = {32'b0, b};
    if (op == OP_MULH || op == OP_MULHSU) ea = {{32{a[31]}}, a};
    if (op == OP_MULH) eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [4:0] rand_mul_op();
    case ($urandom_range(0, 3))
      0:       return OP_MUL;
      1:       return OP_MULH;
      2:       return OP_MULHSU;
      default: return OP_MULHU;
    endcase
  endfunction

  // Issue one request and follow it to its done pulse (or a 40-cycle bound).
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output bit busy_ok);
    bus.start = 1'b1; bus.ALUCtrl = op; bus.rs1 = a; bus.rs2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.ALUCtrl = 5'd0; bus.rs1 = $urandom; bus.rs2 = $urandom;
    lat = -1; res = 'x; busy_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat = n; res = bus.result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h, want 0/0/00000000", bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic test_directed();
    logic [4:0]  ops [6] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHU, OP_MULHSU, OP_MULHSU};
    logic [31:0] as  [6] = '{32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
    logic [31:0] bs  [6] = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] exs [6] = '{32'hFFFFFFEB, 32'h40000000, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001};
    int lat; logic [31:0] res; bit bok;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], lat, res, bok);
      checks++;
      if (res !== exs[i] || lat != LAT || !bok) begin
        errors++;
        $display("FAIL directed[%0d]: result=%h lat=%0d busy_ok=%0b, want %h lat=%0d busy_ok=1", i, res, lat, bok, exs[i], LAT);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.result !== exs[i] || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: result=%h busy=%b done=%b, want %h/0/0", i, bus.result, bus.busy, bus.done, exs[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res, a, b, exp; logic [4:0] op; bit bok;
    for (int i = 0; i < 24; i++) begin
      op = rand_mul_op();
      a  = (i % 5 == 0) ? 32'h80000000 : $urandom;
      b  = (i % 7 == 0) ? 32'hFFFFFFFF : $urandom;
      exp = ref_mul(op, a, b);
      run_op(op, a, b, lat, res, bok);
      checks++;
`ifdef MUL_EARLY_OUT_EN
      if (res !== exp || lat < 3 || lat > LAT || !bok) begin
`else
      if (res !== exp || lat != LAT || !bok) begin
`endif
        errors++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: result=%h lat=%0d, want %h", i, op, a, b, res, lat, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_filter();
    logic [4:0] code; bit stayed;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) code = 5'b00000;
      else begin
        do code = 5'($urandom_range(0, 31)); while (code >= OP_MUL && code <= OP_MULHU);
      end
      bus.start = 1'b1; bus.ALUCtrl = code; bus.rs1 = $urandom; bus.rs2 = $urandom;
      @(posedge clk); #1 bus.start = 1'b0;
      stayed = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (bus.busy !== 1'b0) stayed = 1'b0;
      end
      checks++;
      if (!stayed) begin
        errors++;
        $display("FAIL filter code=%b: busy went high, want busy 0", code);
      end
    end
  endtask

  task automatic test_busy_start();
    logic [31:0] a, b, exp, res; int lat;
    a = $urandom; b = $urandom; exp = ref_mul(OP_MULH, a, b);
    bus.start = 1'b1; bus.ALUCtrl = OP_MULH; bus.rs1 = a; bus.rs2 = b;
    @(posedge clk); #1 bus.start = 1'b0;
    lat = -1; res = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 5 || n == 20) begin
        bus.start = 1'b1; bus.ALUCtrl = OP_MUL; bus.rs1 = ~a; bus.rs2 = 32'd3;
      end else bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = n; res = bus.result;
        break;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (res !== exp || lat != LAT) begin
      errors++;
      $display("FAIL busy_start: result=%h lat=%0d, want %h lat=%0d", res, lat, exp, LAT);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_idle: busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, res; int lat; bit bok;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    run_op(OP_MULHSU, a1, b1, lat, res, bok);
    checks++;
    if (res !== ref_mul(OP_MULHSU, a1, b1) || lat != LAT) begin
      errors++;
      $display("FAIL b2b_first: result=%h lat=%0d, want %h lat=%0d", res, lat, ref_mul(OP_MULHSU, a1, b1), LAT);
    end
    @(posedge clk); #1;
    run_op(OP_MUL, a2, b2, lat, res, bok);
    checks++;
    if (res !== ref_mul(OP_MUL, a2, b2) || lat != LAT || !bok) begin
      errors++;
      $display("FAIL b2b_second: result=%h lat=%0d, want %h lat=%0d", res, lat, ref_mul(OP_MUL, a2, b2), LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_kill();
    logic [31:0] prev; bit saw_done;
    prev = bus.result;
    bus.start = 1'b1; bus.ALUCtrl = OP_MUL; bus.rs1 = $urandom; bus.rs2 = $urandom | 32'h1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk); #1 bus.kill = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.result !== prev) begin
      errors++;
      $display("FAIL kill_calc: busy=%b result=%h, want 0 %h", bus.busy, bus.result, prev);
    end
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.result !== prev) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL kill_nodone: done or result changed after kill, want no done and result %h", prev);
    end
    bus.start = 1'b1; bus.kill = 1'b1; bus.ALUCtrl = OP_MULHU;
    @(posedge clk); #1 bus.start = 1'b0; bus.kill = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL kill_idle: busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res, a, b; bit bok;
    bus.start = 1'b1; bus.ALUCtrl = OP_MULH; bus.rs1 = $urandom; bus.rs2 = $urandom;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.result !== 32'h0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b result=%h done=%b, want 0/00000000/0", bus.busy, bus.result, bus.done);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    a = $urandom; b = $urandom;
    run_op(OP_MULHU, a, b, lat, res, bok);
    checks++;
    if (res !== ref_mul(OP_MULHU, a, b) || lat != LAT) begin
      errors++;
      $display("FAIL post_reset: result=%h lat=%0d, want %h lat=%0d", res, lat, ref_mul(OP_MULHU, a, b), LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_early_out();
    int lat; logic [31:0] res; bit bok;
    run_op(OP_MUL, 32'd5, 32'd0, lat, res, bok);
    checks++;
`ifdef MUL_EARLY_OUT_EN
    if (res !== 32'h0 || lat != 3) begin
      errors++;
      $display("FAIL early_zero: result=%h lat=%0d, want 00000000 lat=3", res, lat);
    end
`else
    if (res !== 32'h0 || lat != LAT) begin
      errors++;
      $display("FAIL early_zero: result=%h lat=%0d, want 00000000 lat=%0d", res, lat, LAT);
    end
`endif
    @(negedge clk);
    run_op(OP_MUL, 32'd3, 32'h100, lat, res, bok);
    checks++;
`ifdef MUL_EARLY_OUT_EN
    if (res !== 32'h300 || lat >= LAT || lat < 3) begin
      errors++;
      $display("FAIL early_0x100: result=%h lat=%0d, want 00000300 with shortened latency", res, lat);
    end
`else
    if (res !== 32'h300 || lat != LAT) begin
      errors++;
      $display("FAIL early_0x100: result=%h lat=%0d, want 00000300 lat=%0d", res, lat, LAT);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.ALUCtrl = 5'd0; bus.rs1 = '0; bus.rs2 = '0; bus.kill = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_directed();
    test_random();
    test_filter();
    test_busy_start();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    test_early_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
